// File: rtl/weight_loader_axi_master_if.sv
// weight_loader_axi_master_if: AXI4-Lite write/read channels between the weight loader and the weight memory.
interface weight_loader_axi_master_if #(parameter int ADDR_WIDTH = 32);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic awvalid, awready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wvalid, wready;
  logic [1:0] bresp;
  logic bvalid, bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic arvalid, arready;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rvalid, rready;
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/weight_loader_axi_master.sv
// weight_loader_axi_master: streams 16-bit weights into consecutive AXI4-Lite words, optional read-back checksum verify.
module weight_loader_axi_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int COUNT_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic verify,
  input  logic w_valid,
  output logic w_ready,
  input  logic [15:0] w_data,
  weight_loader_axi_master_if.master axi,
  output logic busy,
  output logic done,
  output logic [2:0] status,
  output logic [31:0] wr_checksum,
  output logic [31:0] rd_checksum
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, FETCH, W_REQ, W_RESP, R_REQ, R_RESP, DONE} state_t;
  state_t state, state_next;
  logic [ADDR_WIDTH-1:0] base, addr;
  logic [COUNT_WIDTH-1:0] cnt, idx;
  logic [15:0] weight;
  logic [TW-1:0] tcnt;
  logic [31:0] rd_sum_next;
  logic ver, aw_done, w_done, last, to, abort, resp_err, timed_out, mism;
  assign last = idx + COUNT_WIDTH'(1) == cnt;
  assign to = tcnt == TW'(TIMEOUT_CYCLES - 1);
  // address is derived from idx, so it stays put until the handshake that advances idx
  assign addr = base + ADDR_WIDTH'({idx, 2'b00});
  assign rd_sum_next = rd_checksum + (axi.rresp == 2'b00 ? {16'b0, axi.rdata[15:0]} : 32'b0);
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_next;
  end
  always_comb begin
    state_next = state;
    abort = 1'b0;
    case (state)
      IDLE: if (start) state_next = count == '0 ? DONE : FETCH;
      FETCH: if (w_valid) state_next = W_REQ; else abort = to;
      W_REQ: if ((aw_done || axi.awready) && (w_done || axi.wready)) state_next = W_RESP; else abort = to;
      W_RESP: if (axi.bvalid) state_next = !last ? FETCH : ver ? R_REQ : DONE; else abort = to;
      R_REQ: if (axi.arready) state_next = R_RESP; else abort = to;
      R_RESP: if (axi.rvalid) state_next = last ? DONE : R_REQ; else abort = to;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      base <= '0;
      cnt <= '0;
      idx <= '0;
      weight <= '0;
      tcnt <= '0;
      ver <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      resp_err <= 1'b0;
      timed_out <= 1'b0;
      mism <= 1'b0;
      wr_checksum <= '0;
      rd_checksum <= '0;
    end else begin
      tcnt <= state_next != state ? '0 : tcnt == TW'(TIMEOUT_CYCLES) ? tcnt : tcnt + TW'(1);
      if (abort) timed_out <= 1'b1;
      case (state)
        IDLE: if (start) begin
          base <= {base_addr[ADDR_WIDTH-1:2], 2'b00};
          cnt <= count;
          ver <= verify;
          idx <= '0;
          resp_err <= 1'b0;
          timed_out <= 1'b0;
          mism <= 1'b0;
          wr_checksum <= '0;
          rd_checksum <= '0;
        end
        FETCH: if (w_valid) begin
          weight <= w_data;
          wr_checksum <= wr_checksum + {16'b0, w_data};
          aw_done <= 1'b0;
          w_done <= 1'b0;
        end
        W_REQ: begin
          aw_done <= aw_done | axi.awready;
          w_done <= w_done | axi.wready;
        end
        W_RESP: if (axi.bvalid) begin
          resp_err <= resp_err | (axi.bresp != 2'b00);
          idx <= last ? '0 : idx + COUNT_WIDTH'(1);
        end
        R_RESP: if (axi.rvalid) begin
          resp_err <= resp_err | (axi.rresp != 2'b00);
          rd_checksum <= rd_sum_next;
          idx <= idx + COUNT_WIDTH'(1);
          if (last) mism <= wr_checksum != rd_sum_next;
        end
        default: ;
      endcase
    end
  end
  always_comb begin
    w_ready = state == FETCH;
    axi.awvalid = state == W_REQ && !aw_done;
    axi.wvalid = state == W_REQ && !w_done;
    axi.awaddr = addr;
    axi.wdata = {16'b0, weight};
    axi.wstrb = (state == W_REQ || state == W_RESP) ? 4'b0011 : 4'b0000;
    axi.bready = state == W_RESP;
    axi.arvalid = state == R_REQ;
    axi.araddr = addr;
    axi.rready = state == R_RESP;
    busy = state != IDLE && state != DONE;
    done = state == DONE;
    status = {timed_out, mism, resp_err};
  end
endmodule

// File: tb/tb_weight_loader_axi_master.sv
// tb_weight_loader_axi_master: table-driven loads against a small AXI4-Lite slave model, plus timeout/reset/zero-count sequences.
module tb_weight_loader_axi_master;
  localparam int TO = 32;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, verify = 1'b0, w_valid = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] count = '0, w_data = '0;
  logic w_ready, busy, done;
  logic [2:0] status;
  logic [31:0] wr_checksum, rd_checksum;
  weight_loader_axi_master_if axi();
  weight_loader_axi_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .verify(verify), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .axi(axi),
    .busy(busy), .done(done), .status(status), .wr_checksum(wr_checksum), .rd_checksum(rd_checksum)
  );
  always #5 clk = ~clk;
  int aw_lat = 0, w_lat = 0, lim = 256;
  logic aw_never = 1'b0;
  int aw_wait = 0, w_wait = 0;
  always @(posedge clk) begin
    aw_wait <= (axi.awvalid && !axi.awready) ? aw_wait + 1 : 0;
    w_wait <= (axi.wvalid && !axi.wready) ? w_wait + 1 : 0;
  end
  assign axi.awready = !aw_never && aw_wait >= aw_lat;
  assign axi.wready = w_wait >= w_lat;
  assign axi.arready = 1'b1;
  assign axi.bresp = 2'b00;
  logic [31:0] mem [256];
  logic [31:0] wlog_addr [64];
  logic [3:0] wlog_strb [64];
  int n_wr = 0, n_rd = 0;
  logic got_aw = 1'b0, got_w = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      axi.bvalid <= 1'b0;
      axi.rvalid <= 1'b0;
      axi.rdata <= '0;
      axi.rresp <= 2'b00;
      got_aw <= 1'b0;
      got_w <= 1'b0;
    end else begin
      if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
      if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
      if ((got_aw || (axi.awvalid && axi.awready)) && (got_w || (axi.wvalid && axi.wready))) begin
        mem[axi.awaddr[9:2]] <= axi.wdata;
        wlog_addr[n_wr & 63] <= axi.awaddr;
        wlog_strb[n_wr & 63] <= axi.wstrb;
        n_wr <= n_wr + 1;
        axi.bvalid <= 1'b1;
        got_aw <= 1'b0;
        got_w <= 1'b0;
      end else begin
        if (axi.awvalid && axi.awready) got_aw <= 1'b1;
        if (axi.wvalid && axi.wready) got_w <= 1'b1;
      end
      if (axi.arvalid && axi.arready) begin
        axi.rvalid <= 1'b1;
        axi.rdata <= mem[axi.araddr[9:2]];
        axi.rresp <= int'(axi.araddr[31:2]) >= lim ? 2'b10 : 2'b00;
        n_rd <= n_rd + 1;
      end
    end
  end
  int n_done = 0, n_aw = 0, n_ar = 0, n_ovl = 0;
  always @(posedge clk) if (!rst) begin
    if (done) n_done <= n_done + 1;
    if (axi.awvalid) n_aw <= n_aw + 1;
    if (axi.arvalid) n_ar <= n_ar + 1;
    if (axi.awvalid && w_ready) n_ovl <= n_ovl + 1;
  end
  int n_chk = 0, n_bad = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  typedef struct {
    logic [15:0] cnt;
    logic [31:0] base;
    logic ver;
    logic [3:0][15:0] w;
    int gap, alat, wlat, lim;
    logic [31:0] exp_wr, exp_rd;
    logic [2:0] exp_st;
  } vec_t;
  function automatic vec_t mk(input logic [15:0] c, input logic [31:0] b, input logic v,
                              input logic [63:0] w, input int gap, input int al, input int wl,
                              input int li, input logic [31:0] ew, input logic [31:0] er,
                              input logic [2:0] es);
    vec_t r;
    r.cnt = c; r.base = b; r.ver = v; r.w = w; r.gap = gap; r.alat = al; r.wlat = wl;
    r.lim = li; r.exp_wr = ew; r.exp_rd = er; r.exp_st = es;
    return r;
  endfunction
  task automatic push(input logic [15:0] d);
    int n = 0;
    w_valid = 1'b1;
    w_data = d;
    while (!w_ready && n < 200) begin @(negedge clk); n++; end
    chk("w_ready wait", w_ready, 1);
    @(negedge clk);
    w_valid = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < 2000) begin @(negedge clk); n++; end
    chk("done seen", done, 1);
  endtask
  task automatic check_reset(input string tag);
    chk({tag, " ctrl"}, {w_ready, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
                         busy, done, status, axi.wstrb}, 0);
    chk({tag, " addr"}, {axi.awaddr, axi.araddr}, 0);
    chk({tag, " wdata"}, axi.wdata, 0);
    chk({tag, " sums"}, {wr_checksum, rd_checksum}, 0);
  endtask
  task automatic run_load(input vec_t v, input string tag);
    int wr0, rd0, dn0, ov0;
    logic [31:0] a;
    aw_lat = v.alat; w_lat = v.wlat; lim = v.lim;
    wr0 = n_wr; rd0 = n_rd; dn0 = n_done; ov0 = n_ovl;
    @(negedge clk);
    start = 1'b1; base_addr = v.base; count = v.cnt; verify = v.ver;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy/w_ready at T+1"}, {busy, w_ready}, 2'b11);
    for (int i = 0; i < int'(v.cnt); i++) begin
      if (i > 0) for (int g = 0; g < v.gap; g++) begin start = 1'b1; count = 16'd9; @(negedge clk); end
      start = 1'b0;
      push(v.w[i]);
    end
    wait_done();
    chk({tag, " wr_checksum"}, wr_checksum, v.exp_wr);
    chk({tag, " rd_checksum"}, rd_checksum, v.exp_rd);
    chk({tag, " status"}, status, v.exp_st);
    @(negedge clk);
    chk({tag, " done pulses"}, n_done - dn0, 1);
    chk({tag, " busy after"}, {busy, done}, 0);
    chk({tag, " writes"}, n_wr - wr0, v.cnt);
    for (int i = 0; i < int'(v.cnt); i++) begin
      a = (v.base & 32'hFFFF_FFFC) + 32'(4 * i);
      chk($sformatf("%s wr%0d addr/strb", tag, i), {wlog_addr[(wr0 + i) & 63], wlog_strb[(wr0 + i) & 63]}, {a, 4'b0011});
      chk($sformatf("%s wr%0d data", tag, i), mem[a[9:2]], {16'b0, v.w[i]});
    end
    chk({tag, " reads"}, n_rd - rd0, v.ver ? v.cnt : 16'd0);
    chk({tag, " awvalid during fetch"}, n_ovl - ov0, 0);
  endtask
  initial begin
    vec_t vecs [5];
    vec_t follow;
    int aw0, ar0, wr0, n;
    vecs[0] = mk(3, 32'h0, 1, {16'h0, 16'h33, 16'h22, 16'h11}, 0, 0, 0, 256, 32'h66, 32'h66, 3'b000);
    vecs[1] = mk(2, 32'h338, 1, {16'h0, 16'h0, 16'h7, 16'h5}, 0, 0, 0, 207, 32'hC, 32'h5, 3'b011);
    vecs[2] = mk(4, 32'h0, 0, {16'h400, 16'h300, 16'h200, 16'h100}, 5, 0, 0, 256, 32'hA00, 32'h0, 3'b000);
    vecs[3] = mk(2, 32'h13, 1, {16'h0, 16'h0, 16'h8000, 16'hFFFF}, 0, 3, 0, 256, 32'h17FFF, 32'h17FFF, 3'b000);
    vecs[4] = mk(1, 32'h40, 1, {16'h0, 16'h0, 16'h0, 16'h1234}, 0, 0, 2, 256, 32'h1234, 32'h1234, 3'b000);
    follow = mk(1, 32'h80, 1, {16'h0, 16'h0, 16'h0, 16'h00AB}, 0, 0, 0, 256, 32'hAB, 32'hAB, 3'b000);
    repeat (3) @(negedge clk);
    check_reset("init");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) run_load(vecs[i], $sformatf("v%0d", i));
    aw0 = n_aw; ar0 = n_ar;
    @(negedge clk);
    start = 1'b1; count = 16'd0; verify = 1'b1; base_addr = 32'h100;
    @(negedge clk);
    start = 1'b0;
    chk("count0 done at T+1", {done, busy, status}, 5'b10000);
    @(negedge clk);
    chk("count0 single pulse", done, 0);
    repeat (5) @(negedge clk);
    chk("count0 no axi", (n_aw - aw0) + (n_ar - ar0), 0);
    aw_never = 1'b1; aw_lat = 0; w_lat = 0;
    aw0 = n_aw;
    @(negedge clk);
    start = 1'b1; count = 16'd1; verify = 1'b1; base_addr = 32'h0;
    @(negedge clk);
    start = 1'b0;
    push(16'h0055);
    wait_done();
    chk("timeout status", status, 3'b100);
    chk("timeout awvalid cycles", n_aw - aw0, TO);
    chk("timeout valids dropped", {busy, axi.awvalid, axi.wvalid}, 0);
    chk("timeout wr_checksum", wr_checksum, 32'h55);
    @(negedge clk);
    chk("timeout done once", {busy, done}, 0);
    aw_never = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    aw_lat = 3; w_lat = 0; lim = 256;
    wr0 = n_wr;
    @(negedge clk);
    start = 1'b1; count = 16'd3; verify = 1'b0; base_addr = 32'h0;
    @(negedge clk);
    start = 1'b0;
    push(16'h0001);
    push(16'h0002);
    n = 0;
    while (!(axi.bready && axi.bvalid && n_wr - wr0 == 2) && n < 200) begin @(negedge clk); n++; end
    chk("reached second W_RESP", {axi.bready, axi.bvalid}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid-rst");
    rst = 1'b0;
    run_load(follow, "after-rst");
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
